// File: rtl/clock_divided_timer.sv
// clock_divided_timer: multi-channel prescaled timer with compare match, sticky flags and a combined IRQ.
// Optional per-channel input capture is built when CLOCK_DIVIDED_TIMER_CAPTURE_EN is defined.
module clock_divided_timer #(
   parameter int P_CHANNELS         = 4,
   parameter int P_WIDTH            = 32,
   parameter int P_DIV_WIDTH        = 16,
   parameter int P_DEFAULT_DIVISION = 50,
   localparam int CH_W              = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
   input  logic                          I_CLK,
   input  logic                          I_RESET,
   input  logic                          I_WR_EN,
   input  logic [CH_W-1:0]               I_WR_CH,
   input  logic [1:0]                    I_WR_SEL,
   input  logic [P_WIDTH-1:0]            I_WR_DATA,
   input  logic [P_CHANNELS-1:0]         I_MATCH_CLR,
`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
   input  logic [P_CHANNELS-1:0]         I_CAPTURE,
   output logic [P_CHANNELS*P_WIDTH-1:0] O_CAPTURE,
`endif
   output logic [P_CHANNELS*P_WIDTH-1:0] O_COUNT,
   output logic [P_CHANNELS-1:0]         O_MATCH,
   output logic [P_CHANNELS-1:0]         O_RUNNING,
   output logic                          O_IRQ
);

   localparam logic [1:0]             SEL_CTRL  = 2'd0;
   localparam logic [1:0]             SEL_DIV   = 2'd1;
   localparam logic [1:0]             SEL_CMP   = 2'd2;
   localparam logic [1:0]             SEL_CNT   = 2'd3;
   localparam logic [P_DIV_WIDTH-1:0] DIV_ZERO  = {P_DIV_WIDTH{1'b0}};
   localparam logic [P_DIV_WIDTH-1:0] DIV_ONE   = {{(P_DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [P_DIV_WIDTH-1:0] DIV_RESET = P_DIV_WIDTH'(P_DEFAULT_DIVISION);
   localparam logic [P_WIDTH-1:0]     CNT_ZERO  = {P_WIDTH{1'b0}};
   localparam logic [P_WIDTH-1:0]     CNT_ONE   = {{(P_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [P_WIDTH-1:0]     CNT_ONES  = {P_WIDTH{1'b1}};

   logic [P_CHANNELS-1:0] match_vec_s;
   logic [P_CHANNELS-1:0] irq_en_vec_s;
   logic                  irq_q;
   logic                  irq_d;

`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
   logic [P_CHANNELS-1:0] cap_meta_q, cap_meta_d;
   logic [P_CHANNELS-1:0] cap_sync_q, cap_sync_d;
   logic [P_CHANNELS-1:0] cap_prev_q, cap_prev_d;
   logic [P_CHANNELS-1:0] cap_rise_s;

   // two-flop synchroniser plus one delayed copy for rising-edge detection
   always_comb begin
      cap_meta_d = I_CAPTURE;
      cap_sync_d = cap_meta_q;
      cap_prev_d = cap_sync_q;
      cap_rise_s = cap_sync_q & ~cap_prev_q;
   end

   // capture synchroniser registers
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         cap_meta_q <= {P_CHANNELS{1'b0}};
         cap_sync_q <= {P_CHANNELS{1'b0}};
         cap_prev_q <= {P_CHANNELS{1'b0}};
      end else begin
         cap_meta_q <= cap_meta_d;
         cap_sync_q <= cap_sync_d;
         cap_prev_q <= cap_prev_d;
      end
   end
`endif

   genvar c;
   generate
      for (c = 0; c < P_CHANNELS; c++) begin : g_ch
         logic [3:0]             ctrl_q, ctrl_d;
         logic [P_DIV_WIDTH-1:0] div_q, div_d;
         logic [P_DIV_WIDTH-1:0] pre_q, pre_d;
         logic [P_WIDTH-1:0]     cmp_q, cmp_d;
         logic [P_WIDTH-1:0]     cnt_q, cnt_d;
         logic                   match_q, match_d;
         logic                   wr_ctrl_s, wr_div_s, wr_cmp_s, wr_cnt_s;
         logic                   raw_tick_s, tick_s, match_ev_s;
         logic [P_DIV_WIDTH-1:0] div_eff_s;

         // decode the write port for this channel; out-of-range channels never match
         always_comb begin
            wr_ctrl_s = 1'b0;
            wr_div_s  = 1'b0;
            wr_cmp_s  = 1'b0;
            wr_cnt_s  = 1'b0;
            if (I_WR_EN && (I_WR_CH == CH_W'(c))) begin
               case (I_WR_SEL)
                  SEL_CTRL: wr_ctrl_s = 1'b1;
                  SEL_DIV:  wr_div_s  = 1'b1;
                  SEL_CMP:  wr_cmp_s  = 1'b1;
                  SEL_CNT:  wr_cnt_s  = 1'b1;
                  default:  wr_ctrl_s = 1'b0;
               endcase
            end else begin
               wr_ctrl_s = 1'b0;
            end
         end

         // prescaler, counter, control and match next-state; a count write suppresses the tick
         always_comb begin
            div_eff_s  = (div_q == DIV_ZERO) ? DIV_ONE : div_q;
            raw_tick_s = ctrl_q[0] && (pre_q == (div_eff_s - DIV_ONE));
            tick_s     = raw_tick_s && !wr_cnt_s;
            if (ctrl_q[2]) begin
               match_ev_s = tick_s && (cnt_q == CNT_ZERO);
            end else begin
               match_ev_s = tick_s && (cnt_q == cmp_q);
            end

            if (wr_ctrl_s || wr_div_s || raw_tick_s) begin
               pre_d = DIV_ZERO;
            end else if (ctrl_q[0]) begin
               pre_d = pre_q + DIV_ONE;
            end else begin
               pre_d = pre_q;
            end

            if (wr_cnt_s) begin
               cnt_d = I_WR_DATA;
            end else if (match_ev_s) begin
               cnt_d = ctrl_q[2] ? cmp_q : CNT_ZERO;
            end else if (tick_s) begin
               cnt_d = ctrl_q[2] ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
            end else begin
               cnt_d = cnt_q;
            end

            if (wr_ctrl_s) begin
               ctrl_d = I_WR_DATA[3:0];
            end else if (match_ev_s && ctrl_q[1]) begin
               ctrl_d = {ctrl_q[3:1], 1'b0};
            end else begin
               ctrl_d = ctrl_q;
            end

            div_d = wr_div_s ? I_WR_DATA[P_DIV_WIDTH-1:0] : div_q;
            cmp_d = wr_cmp_s ? I_WR_DATA : cmp_q;

            if (match_ev_s) begin
               match_d = 1'b1;
            end else if (I_MATCH_CLR[c]) begin
               match_d = 1'b0;
            end else begin
               match_d = match_q;
            end
         end

         // channel state registers
         always_ff @(posedge I_CLK) begin
            if (I_RESET) begin
               ctrl_q  <= 4'd0;
               div_q   <= DIV_RESET;
               pre_q   <= DIV_ZERO;
               cmp_q   <= CNT_ONES;
               cnt_q   <= CNT_ZERO;
               match_q <= 1'b0;
            end else begin
               ctrl_q  <= ctrl_d;
               div_q   <= div_d;
               pre_q   <= pre_d;
               cmp_q   <= cmp_d;
               cnt_q   <= cnt_d;
               match_q <= match_d;
            end
         end

         assign O_COUNT[c*P_WIDTH +: P_WIDTH] = cnt_q;
         assign match_vec_s[c]                = match_q;
         assign irq_en_vec_s[c]               = ctrl_q[3];
         assign O_RUNNING[c]                  = ctrl_q[0];

`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
         logic [P_WIDTH-1:0] cap_q, cap_d;

         // latch the live count on a synchronised rising edge
         always_comb begin
            if (cap_rise_s[c]) begin
               cap_d = cnt_q;
            end else begin
               cap_d = cap_q;
            end
         end

         // capture register
         always_ff @(posedge I_CLK) begin
            if (I_RESET) begin
               cap_q <= CNT_ZERO;
            end else begin
               cap_q <= cap_d;
            end
         end

         assign O_CAPTURE[c*P_WIDTH +: P_WIDTH] = cap_q;
`endif
      end
   endgenerate

   // combined interrupt request, one cycle behind the flags
   always_comb begin
      irq_d = |(match_vec_s & irq_en_vec_s);
   end

   // interrupt register
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign O_MATCH = match_vec_s;
   assign O_IRQ   = irq_q;

endmodule

// File: tb/tb_clock_divided_timer.sv
// Directed bench for clock_divided_timer: a 4-channel 32-bit instance plus a 3-channel
// instance for out-of-range channel writes.
module tb_clock_divided_timer;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en;
   logic [1:0]   wr_ch;
   logic [1:0]   wr_sel;
   logic [31:0]  wr_data;
   logic [3:0]   match_clr;
   logic [127:0] count;
   logic [3:0]   match;
   logic [3:0]   running;
   logic         irq;

   logic         b_wr_en;
   logic [1:0]   b_wr_ch;
   logic [1:0]   b_wr_sel;
   logic [7:0]   b_wr_data;
   logic [2:0]   b_match_clr;
   logic [23:0]  b_count;
   logic [2:0]   b_match;
   logic [2:0]   b_running;
   logic         b_irq;

`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
   logic [3:0]   capture;
   logic [127:0] capture_out;
   logic [2:0]   b_capture;
   logic [23:0]  b_capture_out;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   clock_divided_timer dut (
      .I_CLK       (clk),
      .I_RESET     (rst),
      .I_WR_EN     (wr_en),
      .I_WR_CH     (wr_ch),
      .I_WR_SEL    (wr_sel),
      .I_WR_DATA   (wr_data),
      .I_MATCH_CLR (match_clr),
`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
      .I_CAPTURE   (capture),
      .O_CAPTURE   (capture_out),
`endif
      .O_COUNT     (count),
      .O_MATCH     (match),
      .O_RUNNING   (running),
      .O_IRQ       (irq)
   );

   clock_divided_timer #(
      .P_CHANNELS         (3),
      .P_WIDTH            (8),
      .P_DIV_WIDTH        (8),
      .P_DEFAULT_DIVISION (50)
   ) dut3 (
      .I_CLK       (clk),
      .I_RESET     (rst),
      .I_WR_EN     (b_wr_en),
      .I_WR_CH     (b_wr_ch),
      .I_WR_SEL    (b_wr_sel),
      .I_WR_DATA   (b_wr_data),
      .I_MATCH_CLR (b_match_clr),
`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
      .I_CAPTURE   (b_capture),
      .O_CAPTURE   (b_capture_out),
`endif
      .O_COUNT     (b_count),
      .O_MATCH     (b_match),
      .O_RUNNING   (b_running),
      .O_IRQ       (b_irq)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int sel, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_ch   = ch[1:0];
      wr_sel  = sel[1:0];
      wr_data = data;
      step(1);
      wr_en   = 1'b0;
   endtask

   function automatic logic [63:0] cnt(input int c);
      return 64'(count[c*32 +: 32]);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_ch = 2'd0; wr_sel = 2'd0; wr_data = 32'd0; match_clr = 4'd0;
      b_wr_en = 1'b0; b_wr_ch = 2'd0; b_wr_sel = 2'd0; b_wr_data = 8'd0; b_match_clr = 3'd0;
`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
      capture = 4'd0; b_capture = 3'd0;
`endif
      step(2);
      check("reset_count", 64'(|count), 64'd0);
      check("reset_match", 64'(match), 64'd0);
      check("reset_running", 64'(running), 64'd0);
      check("reset_irq", 64'(irq), 64'd0);
`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
      check("reset_capture", 64'(|capture_out), 64'd0);
`endif
      rst = 1'b0;

      // default divisor 50 on ch0
      wr(0, 0, 32'h1);
      check("ch0_running", 64'(running), 64'h1);
      step(49); check("ch0_cnt_49cyc", cnt(0), 64'd0);
      step(1);  check("ch0_cnt_50cyc", cnt(0), 64'd1);
      step(50); check("ch0_cnt_100cyc", cnt(0), 64'd2);
      wr(0, 0, 32'h0);

      // continuous up, divisor 4, compare 3, irq enabled
      wr(1, 1, 32'd4); wr(1, 2, 32'd3); wr(1, 0, 32'h9);
      step(4); check("up_cnt1", cnt(1), 64'd1);
      step(4); check("up_cnt2", cnt(1), 64'd2);
      step(4); check("up_cnt3", cnt(1), 64'd3);
      check("up_nomatch_yet", 64'(match[1]), 64'd0);
      step(4); check("up_wrap", cnt(1), 64'd0);
      check("up_match_set", 64'(match[1]), 64'd1);
      check("up_irq_lag", 64'(irq), 64'd0);
      step(1); check("up_irq_set", 64'(irq), 64'd1);
      match_clr = 4'b0010; step(1); match_clr = 4'd0;
      check("up_match_clr", 64'(match[1]), 64'd0);
      check("up_irq_still", 64'(irq), 64'd1);
      step(1); check("up_irq_clr", 64'(irq), 64'd0);
      wr(1, 0, 32'h0);

      // one-shot down from 5, compare 7, divisor 1, irq disabled
      wr(2, 3, 32'd5); wr(2, 2, 32'd7); wr(2, 1, 32'd1); wr(2, 0, 32'h7);
      check("dn_start", cnt(2), 64'd5);
      for (int k = 1; k <= 5; k++) begin
         step(1); check("dn_cnt", cnt(2), 64'(5 - k));
      end
      step(1);
      check("dn_reload", cnt(2), 64'd7);
      check("dn_stopped", 64'(running[2]), 64'd0);
      check("dn_match", 64'(match[2]), 64'd1);
      step(1); check("dn_irq_masked", 64'(irq), 64'd0);
      step(3); check("dn_hold", cnt(2), 64'd7);

      // count write on the tick cycle, then clear colliding with a match
      wr(3, 1, 32'd4); wr(3, 2, 32'd1000); wr(3, 0, 32'h1);
      step(3); check("col_pre", cnt(3), 64'd0);
      wr(3, 3, 32'd100); check("col_cntwr", cnt(3), 64'd100);
      step(3); check("col_hold", cnt(3), 64'd100);
      step(1); check("col_prescale_kept", cnt(3), 64'd101);
      wr(3, 2, 32'd102);
      step(6); check("col_before_match", cnt(3), 64'd102);
      match_clr = 4'b1000; step(1); match_clr = 4'd0;
      check("col_set_wins", 64'(match[3]), 64'd1);
      check("col_wrap", cnt(3), 64'd0);
      wr(3, 0, 32'h0);

      // out-of-range channel on a 3-channel instance
      b_wr_en = 1'b1; b_wr_ch = 2'd3; b_wr_sel = 2'd3; b_wr_data = 8'h55; step(1);
      b_wr_sel = 2'd0; b_wr_data = 8'h01; step(1);
      b_wr_en = 1'b0;
      check("oor_count", 64'(b_count), 64'd0);
      check("oor_running", 64'(b_running), 64'd0);
      b_wr_en = 1'b1; b_wr_ch = 2'd2; b_wr_sel = 2'd3; b_wr_data = 8'h55; step(1);
      b_wr_en = 1'b0;
      check("inrange_count", 64'(b_count), 64'h550000);

      // mid-run reset with ch0 at 9 and its match flag set
      wr(0, 3, 32'd0); wr(0, 1, 32'd1); wr(0, 2, 32'd9); wr(0, 0, 32'h1);
      step(10); check("mr_wrap", cnt(0), 64'd0);
      check("mr_match", 64'(match[0]), 64'd1);
      step(9); check("mr_at9", cnt(0), 64'd9);
      rst = 1'b1; step(1); rst = 1'b0;
      check("mr_count", 64'(|count), 64'd0);
      check("mr_match_clr", 64'(match), 64'd0);
      check("mr_running", 64'(running), 64'd0);
      check("mr_irq", 64'(irq), 64'd0);
      wr(0, 0, 32'h1);
      step(49); check("mr_div_49", cnt(0), 64'd0);
      step(1);  check("mr_div_50", cnt(0), 64'd1);
      wr(0, 0, 32'h0);

`ifdef CLOCK_DIVIDED_TIMER_CAPTURE_EN
      wr(3, 3, 32'd0); wr(3, 2, 32'd1000); wr(3, 1, 32'd1); wr(3, 0, 32'h1);
      step(20); check("cap_cnt20", cnt(3), 64'd20);
      capture = 4'b1000;
      step(2); check("cap_latency", 64'(capture_out[96 +: 32]), 64'd0);
      step(1); check("cap_value", 64'(capture_out[96 +: 32]), 64'd22);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
